// File: rtl/alu_bist_sequencer.sv
// alu_bist_sequencer: built-in self-test driver/checker for the 16-bit logic ALU.
// Sweeps all eight opcodes over a COUNT x COUNT operand grid, compares the ALU
// result against an internal golden model, counts passes/fails and captures the
// first failing vector.
// Optional build macro: ALU_BIST_HALT_ON_FAIL_EN ends the sweep at the first mismatch.
module alu_bist_sequencer #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] STEP  = WIDTH'(16'h2003),
    parameter int unsigned      COUNT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2:0]       alu_control,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_dout,
    output logic [15:0]      success_cnt,
    output logic [15:0]      fail_cnt,
    output logic [2:0]       fail_op,
    output logic [WIDTH-1:0] fail_in0,
    output logic [WIDTH-1:0] fail_in1,
    output logic [WIDTH-1:0] fail_dout
);

    localparam int unsigned IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

`ifdef ALU_BIST_HALT_ON_FAIL_EN
    localparam bit HALT_ON_FAIL = 1'b1;
`else
    localparam bit HALT_ON_FAIL = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx0;
    logic [IDX_W-1:0] idx1;
    logic [WIDTH-1:0] expected;
    logic             mismatch;
    logic             last_vec;
    logic             start_run;
    logic             do_check;
    logic             finish;

    // Golden model of the ALU for the vector currently on alu_*
    always_comb begin
        expected = '0;
        unique case (alu_control)
            3'b000: expected = alu_in0 + alu_in1;
            3'b001: expected = alu_in0 & alu_in1;
            3'b010: expected = alu_in0 | alu_in1;
            3'b011: expected = alu_in0 ^ alu_in1;
            3'b100: expected = alu_in0 - alu_in1;
            3'b101: expected = ~(alu_in0 & alu_in1);
            3'b110: expected = ~(alu_in0 | alu_in1);
            3'b111: expected = ~(alu_in0 ^ alu_in1);
        endcase
        mismatch = (alu_dout != expected);
        last_vec = (alu_control == 3'b111) && (idx1 == IDX_LAST) && (idx0 == IDX_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        do_check   = 1'b0;
        finish     = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                    start_run  = 1'b1;
                end
            end
            S_RUN: begin
                do_check = 1'b1;
                if (last_vec || (HALT_ON_FAIL && mismatch)) begin
                    state_next = S_DONE;
                    finish     = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Vector generation, result counting and first-failure capture
    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            alu_control <= '0;
            alu_in0     <= '0;
            alu_in1     <= '0;
            idx0        <= '0;
            idx1        <= '0;
            success_cnt <= '0;
            fail_cnt    <= '0;
            fail_op     <= '0;
            fail_in0    <= '0;
            fail_in1    <= '0;
            fail_dout   <= '0;
        end else if (start_run) begin
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            alu_control <= '0;
            alu_in0     <= '0;
            alu_in1     <= '0;
            idx0        <= '0;
            idx1        <= '0;
            success_cnt <= '0;
            fail_cnt    <= '0;
            fail_op     <= '0;
            fail_in0    <= '0;
            fail_in1    <= '0;
            fail_dout   <= '0;
        end else if (do_check) begin
            if (mismatch) begin
                if (fail_cnt != CNT_MAX) begin
                    fail_cnt <= fail_cnt + 1'b1;
                end
                if (fail_cnt == '0) begin
                    fail_op   <= alu_control;
                    fail_in0  <= alu_in0;
                    fail_in1  <= alu_in1;
                    fail_dout <= alu_dout;
                end
            end else if (success_cnt != CNT_MAX) begin
                success_cnt <= success_cnt + 1'b1;
            end

            if (finish) begin
                busy        <= 1'b0;
                done        <= 1'b1;
                pass        <= (fail_cnt == '0) && !mismatch;
                alu_control <= '0;
                alu_in0     <= '0;
                alu_in1     <= '0;
                idx0        <= '0;
                idx1        <= '0;
            end else if (idx0 == IDX_LAST) begin
                idx0    <= '0;
                alu_in0 <= '0;
                if (idx1 == IDX_LAST) begin
                    idx1        <= '0;
                    alu_in1     <= '0;
                    alu_control <= alu_control + 3'd1;
                end else begin
                    idx1    <= idx1 + 1'b1;
                    alu_in1 <= alu_in1 + STEP;
                end
            end else begin
                idx0    <= idx0 + 1'b1;
                alu_in0 <= alu_in0 + STEP;
            end
        end
    end

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Self-checking bench for alu_bist_sequencer with a behavioural ALU that can
// inject faults (1: op 011 returns in0&in1, 2: op 100 returns in0+in1).
module tb_alu_bist_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, pass;
    logic [2:0]  alu_control;
    logic [15:0] alu_in0, alu_in1, alu_dout;
    logic [15:0] success_cnt, fail_cnt;
    logic [2:0]  fail_op;
    logic [15:0] fail_in0, fail_in1, fail_dout;
    int          fault;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    alu_bist_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .alu_control(alu_control), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_dout(alu_dout),
        .success_cnt(success_cnt), .fail_cnt(fail_cnt),
        .fail_op(fail_op), .fail_in0(fail_in0), .fail_in1(fail_in1),
        .fail_dout(fail_dout)
    );

    // Behavioural ALU with optional fault
    always_comb begin
        case (alu_control)
            3'b000: alu_dout = alu_in0 + alu_in1;
            3'b001: alu_dout = alu_in0 & alu_in1;
            3'b010: alu_dout = alu_in0 | alu_in1;
            3'b011: alu_dout = (fault == 1) ? (alu_in0 & alu_in1) : (alu_in0 ^ alu_in1);
            3'b100: alu_dout = (fault == 2) ? (alu_in0 + alu_in1) : (alu_in0 - alu_in1);
            3'b101: alu_dout = ~(alu_in0 & alu_in1);
            3'b110: alu_dout = ~(alu_in0 | alu_in1);
            default: alu_dout = ~(alu_in0 ^ alu_in1);
        endcase
    end

    typedef struct {
        int          fault;
        int          cycles;
        logic [15:0] succ;
        logic [15:0] fails;
        logic        pass;
        logic [2:0]  fop;
        logic [15:0] fin0;
        logic [15:0] fin1;
        logic [15:0] fdout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse (or hold) start, return edges from T0 until done is seen
    task automatic run_sweep(input bit hold, output int cycles);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        if (!hold) begin
            @(negedge clk) start = 1'b0;
        end
        cycles = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (done) break;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL sweep_timeout: done=%0b after %0d cycles, required 1", done, cycles);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_ctl"},  32'(alu_control), 32'd0);
        check({tag, "_in0"},  32'(alu_in0), 32'd0);
        check({tag, "_in1"},  32'(alu_in1), 32'd0);
        check({tag, "_succ"}, 32'(success_cnt), 32'd0);
        check({tag, "_fail"}, 32'(fail_cnt), 32'd0);
        check({tag, "_fdout"}, 32'(fail_dout), 32'd0);
    endtask

    vec_t vecs[3];
    int   cyc;

    initial begin
`ifdef ALU_BIST_HALT_ON_FAIL_EN
        vecs[0] = '{0, 512, 16'd512, 16'd0, 1'b1, 3'd0, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{1, 194, 16'd193, 16'd1, 1'b0, 3'd3, 16'h2003, 16'h0000, 16'h0000};
        vecs[2] = '{2, 265, 16'd264, 16'd1, 1'b0, 3'd4, 16'h0000, 16'h2003, 16'h2003};
`else
        vecs[0] = '{0, 512, 16'd512, 16'd0, 1'b1, 3'd0, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{1, 512, 16'd449, 16'd63, 1'b0, 3'd3, 16'h2003, 16'h0000, 16'h0000};
        vecs[2] = '{2, 512, 16'd456, 16'd56, 1'b0, 3'd4, 16'h0000, 16'h2003, 16'h2003};
`endif
        fault = 0;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk) reset = 1'b0;

        // Table-driven sweeps with and without injected faults
        foreach (vecs[r]) begin
            fault = vecs[r].fault;
            run_sweep(1'b0, cyc);
            check($sformatf("r%0d_cycles", r), 32'(cyc), 32'(vecs[r].cycles));
            check($sformatf("r%0d_succ", r), 32'(success_cnt), 32'(vecs[r].succ));
            check($sformatf("r%0d_fail", r), 32'(fail_cnt), 32'(vecs[r].fails));
            check($sformatf("r%0d_pass", r), 32'(pass), 32'(vecs[r].pass));
            check($sformatf("r%0d_busy", r), 32'(busy), 32'd0);
            check($sformatf("r%0d_fop", r), 32'(fail_op), 32'(vecs[r].fop));
            check($sformatf("r%0d_fin0", r), 32'(fail_in0), 32'(vecs[r].fin0));
            check($sformatf("r%0d_fin1", r), 32'(fail_in1), 32'(vecs[r].fin1));
            check($sformatf("r%0d_fdout", r), 32'(fail_dout), 32'(vecs[r].fdout));
            check($sformatf("r%0d_alu_idle", r), 32'({alu_control, alu_in0, alu_in1} == '0), 32'd1);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("r%0d_done_held", r), 32'(done), 32'd1);
        end
        fault = 0;

        // Vector k=9 appears on alu_* after edge T0+9; first check at T0+1
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        @(posedge clk); #1;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_done_clr", 32'(done), 32'd0);
        check("t1_succ", 32'(success_cnt), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("k9_ctl", 32'(alu_control), 32'd0);
        check("k9_in0", 32'(alu_in0), 32'h2003);
        check("k9_in1", 32'(alu_in1), 32'h2003);
        check("k9_dout", 32'(alu_dout), 32'h4006);

        // Reset sampled at T0+100 aborts the sweep
        repeat (90) @(posedge clk);
        #1;
        check("abort_pre_busy", 32'(busy), 32'd1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("abort");
        @(negedge clk) reset = 1'b0;

        // start on the same edge as reset: reset wins
        @(negedge clk) begin reset = 1'b1; start = 1'b1; end
        @(posedge clk); #1;
        check("rst_start_busy", 32'(busy), 32'd0);
        @(negedge clk) begin reset = 1'b0; start = 1'b0; end
        @(posedge clk); #1;
        check("rst_start_idle", 32'(busy), 32'd0);

        // Clean sweep after abort, start held throughout RUN
        run_sweep(1'b1, cyc);
        check("hold_cycles", 32'(cyc), 32'd512);
        check("hold_succ", 32'(success_cnt), 32'd512);
        check("hold_pass", 32'(pass), 32'd1);
        // start still high in DONE: restart on the next edge clears results
        @(posedge clk); #1;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        check("restart_pass", 32'(pass), 32'd0);
        check("restart_succ", 32'(success_cnt), 32'd0);
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        check("restart_end_done", 32'(done), 32'd1);
        check("restart_end_succ", 32'(success_cnt), 32'd512);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
